// File: rtl/lcd_pkg.sv
// Shared constants, state/phase encodings and byte helpers for the DE2
// character LCD text writer.
package lcd_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_POWERUP = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_IDLE    = 3'd2;
  localparam state_t ST_ADDR1   = 3'd3;
  localparam state_t ST_LINE1   = 3'd4;
  localparam state_t ST_ADDR2   = 3'd5;
  localparam state_t ST_LINE2   = 3'd6;

  typedef logic [2:0] phase_t;
  localparam phase_t PH_IDLE  = 3'd0;
  localparam phase_t PH_SETUP = 3'd1;
  localparam phase_t PH_EN    = 3'd2;
  localparam phase_t PH_HOLD  = 3'd3;
  localparam phase_t PH_WAIT  = 3'd4;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;
  localparam logic [7:0] SPACE    = 8'h20;

  // NUL bytes in the frame are blank cells on the panel.
  function automatic logic [7:0] map_char(input logic [7:0] b);
    if (b == 8'h00) begin
      return SPACE;
    end else begin
      return b;
    end
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// One HD44780 bus write: setup, enable strobe, hold, then execution wait.
// A start seen in the idle phase (including the done cycle) begins setup next cycle.
module lcd_bus_write
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 16,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_CYC       = 2_000,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       ending,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_B   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > CLEAR_WAIT_CYC) ? MAX_C : CLEAR_WAIT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  phase_t          phase_r;
  logic [CW-1:0]   cnt_r;
  logic            clear_r;
  logic [CW-1:0]   wait_last_s;

  // Clear needs the long execution wait.
  always_comb begin
    if (clear_r) begin
      wait_last_s = CLEAR_LAST;
    end else begin
      wait_last_s = WAIT_LAST;
    end
  end

  assign ending = (phase_r == PH_WAIT) && (cnt_r == wait_last_s);

  // Phase sequencer; pins hold their last value between writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_r  <= PH_IDLE;
      cnt_r    <= CNT_ZERO;
      clear_r  <= 1'b0;
      done     <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase_r)
        PH_IDLE: begin
          if (start) begin
            lcd_data <= data;
            lcd_rs   <= rs;
            lcd_en   <= 1'b0;
            clear_r  <= (rs == 1'b0) && (data == CLEAR);
            cnt_r    <= CNT_ZERO;
            phase_r  <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            cnt_r   <= CNT_ZERO;
            lcd_en  <= 1'b1;
            phase_r <= PH_EN;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PH_EN: begin
          if (cnt_r == EN_LAST) begin
            cnt_r   <= CNT_ZERO;
            lcd_en  <= 1'b0;
            phase_r <= PH_HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PH_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r   <= CNT_ZERO;
            phase_r <= PH_WAIT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PH_WAIT: begin
          if (ending) begin
            cnt_r   <= CNT_ZERO;
            done    <= 1'b1;
            phase_r <= PH_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          lcd_en  <= 1'b0;
          phase_r <= PH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Drives a 16x2 HD44780 panel: power-up wait, init commands, then a full
// rewrite of both lines whenever the incoming frame differs from the last one.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 1_000_000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 16,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_CYC       = 2_000,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] lcd_text,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         lcd_on,
  output logic         lcd_blon,
  output logic         busy,
  output logic         frame_done
);

  localparam int            PW      = $clog2(POWERUP_CYC + 1);
  localparam logic [PW-1:0] PU_LAST = PW'(POWERUP_CYC - 1);
  localparam logic [PW-1:0] PU_ZERO = PW'(0);
  localparam logic [PW-1:0] PU_ONE  = PW'(1);

  state_t         state_r;
  state_t         next_state_s;
  logic [PW-1:0]  pu_cnt_r;
  logic [1:0]     init_idx_r;
  logic [3:0]     col_r;
  logic [3:0]     col_next_s;
  logic [255:0]   shadow_r;
  logic           dirty_r;
  logic           busy_r;
  logic           frame_done_r;
  logic           frame_start_s;
  logic           wr_start_s;
  logic           wr_rs_s;
  logic [7:0]     wr_data_s;
  logic           wr_done_s;
  logic           wr_ending_s;

  // Cell i (0..31) is line 1 col 0 at the MSB down to line 2 col 15 at the LSB.
  function automatic logic [7:0] frame_byte(input logic [255:0] f, input logic [4:0] i);
    return f[{~i, 3'b000} +: 8];
  endfunction

  assign col_next_s    = col_r + 4'd1;
  assign frame_start_s = dirty_r || (lcd_text != shadow_r);

  // Sequencing: pick the next write on each done and the next state.
  always_comb begin
    next_state_s = state_r;
    wr_start_s   = 1'b0;
    wr_rs_s      = 1'b0;
    wr_data_s    = 8'h00;
    case (state_r)
      ST_POWERUP: begin
        if (pu_cnt_r == PU_LAST) begin
          wr_start_s   = 1'b1;
          wr_data_s    = init_cmd(2'd0);
          next_state_s = ST_INIT;
        end else begin
          next_state_s = ST_POWERUP;
        end
      end
      ST_INIT: begin
        if (wr_done_s && (init_idx_r == 2'd3)) begin
          next_state_s = ST_IDLE;
        end else if (wr_done_s) begin
          wr_start_s = 1'b1;
          wr_data_s  = init_cmd(init_idx_r + 2'd1);
        end else begin
          next_state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (frame_start_s) begin
          wr_start_s   = 1'b1;
          wr_data_s    = LINE1;
          next_state_s = ST_ADDR1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR1: begin
        if (wr_done_s) begin
          wr_start_s   = 1'b1;
          wr_rs_s      = 1'b1;
          wr_data_s    = map_char(frame_byte(shadow_r, 5'd0));
          next_state_s = ST_LINE1;
        end else begin
          next_state_s = ST_ADDR1;
        end
      end
      ST_LINE1: begin
        if (wr_done_s && (col_r == 4'd15)) begin
          wr_start_s   = 1'b1;
          wr_data_s    = LINE2;
          next_state_s = ST_ADDR2;
        end else if (wr_done_s) begin
          wr_start_s = 1'b1;
          wr_rs_s    = 1'b1;
          wr_data_s  = map_char(frame_byte(shadow_r, {1'b0, col_next_s}));
        end else begin
          next_state_s = ST_LINE1;
        end
      end
      ST_ADDR2: begin
        if (wr_done_s) begin
          wr_start_s   = 1'b1;
          wr_rs_s      = 1'b1;
          wr_data_s    = map_char(frame_byte(shadow_r, 5'd16));
          next_state_s = ST_LINE2;
        end else begin
          next_state_s = ST_ADDR2;
        end
      end
      ST_LINE2: begin
        if (wr_done_s && (col_r == 4'd15)) begin
          next_state_s = ST_IDLE;
        end else if (wr_done_s) begin
          wr_start_s = 1'b1;
          wr_rs_s    = 1'b1;
          wr_data_s  = map_char(frame_byte(shadow_r, {1'b1, col_next_s}));
        end else begin
          next_state_s = ST_LINE2;
        end
      end
      default: begin
        next_state_s = ST_POWERUP;
      end
    endcase
  end

  // State, counters, frame shadow and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_POWERUP;
      pu_cnt_r     <= PU_ZERO;
      init_idx_r   <= 2'd0;
      col_r        <= 4'd0;
      shadow_r     <= 256'd0;
      dirty_r      <= 1'b1;
      busy_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != ST_IDLE);
      frame_done_r <= (state_r == ST_LINE2) && (col_r == 4'd15) && wr_ending_s;
      case (state_r)
        ST_POWERUP: begin
          if (pu_cnt_r != PU_LAST) begin
            pu_cnt_r <= pu_cnt_r + PU_ONE;
          end
        end
        ST_INIT: begin
          if (wr_done_s && (init_idx_r != 2'd3)) begin
            init_idx_r <= init_idx_r + 2'd1;
          end
        end
        ST_IDLE: begin
          // Latch the frame once; later text changes wait for the next frame.
          if (frame_start_s) begin
            shadow_r <= lcd_text;
            dirty_r  <= 1'b0;
          end
        end
        ST_ADDR1, ST_ADDR2: begin
          if (wr_done_s) begin
            col_r <= 4'd0;
          end
        end
        ST_LINE1, ST_LINE2: begin
          if (wr_done_s && (col_r != 4'd15)) begin
            col_r <= col_next_s;
          end
        end
        default: begin
          col_r <= 4'd0;
        end
      endcase
    end
  end

  lcd_bus_write #(
    .SETUP_CYC      (SETUP_CYC),
    .EN_CYC         (EN_CYC),
    .HOLD_CYC       (HOLD_CYC),
    .WAIT_CYC       (WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_bus (
    .clock    (clock),
    .reset    (reset),
    .start    (wr_start_s),
    .rs       (wr_rs_s),
    .data     (wr_data_s),
    .done     (wr_done_s),
    .ending   (wr_ending_s),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en)
  );

  assign lcd_rw     = 1'b0;
  assign lcd_on     = 1'b1;
  assign lcd_blon   = 1'b1;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: an expected-write queue built from the frame
// rules, checked against every enable strobe by a per-cycle monitor.
module tb_lcd_text_writer;

  localparam int P  = 10;
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int H  = 1;
  localparam int W  = 3;
  localparam int CW = 8;

  // EN-rise to EN-rise spacing: strobe, hold, wait, done cycle, next setup.
  localparam int GAP       = E + H + W + 1 + S;
  localparam int CLEAR_GAP = E + H + CW + 1 + S;
  localparam int IDLE_GAP  = GAP + 1;
  localparam int FIRST_GAP = P + S;

  logic         clock;
  logic         reset;
  logic [255:0] lcd_text;
  logic [7:0]   lcd_data;
  logic         lcd_rs;
  logic         lcd_rw;
  logic         lcd_en;
  logic         lcd_on;
  logic         lcd_blon;
  logic         busy;
  logic         frame_done;

  lcd_text_writer #(
    .POWERUP_CYC    (P),
    .SETUP_CYC      (S),
    .EN_CYC         (E),
    .HOLD_CYC       (H),
    .WAIT_CYC       (W),
    .CLEAR_WAIT_CYC (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .lcd_text   (lcd_text),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_on     (lcd_on),
    .lcd_blon   (lcd_blon),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         since    = 0;
  int         rises    = 0;
  int         fd_count = 0;
  int         en_hi    = 0;
  logic       prev_en  = 1'b0;
  logic       prev_fd  = 1'b0;
  logic [8:0] prev_wr  = 9'd0;
  logic [8:0] cap_wr   = 9'd0;
  logic [8:0] last_wr  = 9'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input int gap);
    wr_t e;
    e.rs   = rs;
    e.data = data;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, FIRST_GAP);
    push(1'b0, 8'h0C, GAP);
    push(1'b0, 8'h01, GAP);
    push(1'b0, 8'h06, CLEAR_GAP);
  endtask

  // Line 1 occupies the upper 16 bytes, leftmost column first; NUL shows as space.
  task automatic push_frame(input logic [255:0] t, input int first_gap);
    logic [7:0] b;
    push(1'b0, 8'h80, first_gap);
    for (int c = 0; c < 16; c++) begin
      b = t[255 - 8*c -: 8];
      push(1'b1, (b == 8'h00) ? 8'h20 : b, GAP);
    end
    push(1'b0, 8'hC0, GAP);
    for (int c = 0; c < 16; c++) begin
      b = t[127 - 8*c -: 8];
      push(1'b1, (b == 8'h00) ? 8'h20 : b, GAP);
    end
  endtask

  task automatic wait_frames(input int fd_target, input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fd_count < fd_target) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Monitor: every write strobe is matched against the expected queue.
  always @(posedge clock) begin
    wr_t e;
    #1;
    check("pins_const", 32'({lcd_rw, lcd_on, lcd_blon}), 32'b011);
    if (reset) begin
      since   = 0;
      prev_en = 1'b0;
      prev_fd = 1'b0;
      en_hi   = 0;
    end else begin
      since++;
      if (lcd_en && !prev_en) begin
        rises++;
        check("setup_stable", 32'(prev_wr), 32'({lcd_rs, lcd_data}));
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'({lcd_rs, lcd_data}), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          check("write_data", 32'({lcd_rs, lcd_data}), 32'({e.rs, e.data}));
          check("write_gap", 32'(since), 32'(e.gap));
        end
        since   = 0;
        cap_wr  = {lcd_rs, lcd_data};
        last_wr = {lcd_rs, lcd_data};
        en_hi   = 0;
      end
      if (lcd_en) begin
        en_hi++;
        check("en_data_held", 32'({lcd_rs, lcd_data}), 32'(cap_wr));
      end
      if (!lcd_en && prev_en) begin
        check("en_width", 32'(en_hi), 32'(E));
        check("hold_data", 32'({lcd_rs, lcd_data}), 32'(cap_wr));
      end
      if (frame_done) begin
        fd_count++;
        check("fd_single_cycle", 32'(prev_fd), 32'd0);
        check("fd_while_busy", 32'(busy), 32'd1);
      end
      prev_en = lcd_en;
      prev_fd = frame_done;
      prev_wr = {lcd_rs, lcd_data};
    end
  end

  initial begin
    logic [255:0] t_enter;
    logic [255:0] t_ab;
    logic [255:0] t_done;
    logic [255:0] t_x;
    int base;
    int fdb;
    int n;

    t_enter = 256'("Enter c_real.");
    t_ab    = "ABCDEFGHIJKLMNOP0123456789abcdef";
    t_done  = 256'("Done.");
    t_x     = 256'("x");

    reset    = 1'b0;
    lcd_text = 256'd0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Init then the reset-forced first frame carrying the new text.
    push_init();
    push_frame(t_enter, IDLE_GAP);
    check("model_len", 32'(exp_q.size()), 32'd38);
    check("model_first_gap", 32'(exp_q[0].gap), 32'd11);
    check("model_clear_gap", 32'(exp_q[3].gap), 32'd13);
    check("model_addr1", 32'(exp_q[4].data), 32'h80);
    check("model_l1c0", 32'({exp_q[5].rs, exp_q[5].data}), 32'h120);
    check("model_addr2", 32'(exp_q[21].data), 32'hC0);
    check("model_l2c3", 32'(exp_q[25].data), 32'h45);
    check("model_l2c15", 32'(exp_q[37].data), 32'h2E);
    lcd_text = t_enter;
    reset    = 1'b0;
    wait_frames(1, 1500, "timeout_first_frame");
    repeat (2) @(negedge clock);
    check("first_frame_fd_count", 32'(fd_count), 32'd1);
    check("first_frame_idle", 32'(busy), 32'd0);

    // Stable text: nothing more is written.
    base = rises;
    repeat (500) @(negedge clock);
    check("stable_no_writes", 32'(rises), 32'(base));
    check("stable_idle", 32'(busy), 32'd0);

    // New frame, then change text while line 1 col 5 is being written.
    @(negedge clock);
    lcd_text = t_ab;
    since    = 0;
    base     = rises;
    fdb      = fd_count;
    push_frame(t_ab, 2);
    @(posedge clock);
    #2 check("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (rises < base + 7 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("timeout_col5", 32'(n < 200), 32'd1);
    lcd_text = t_done;
    push_frame(t_done, IDLE_GAP);
    wait_frames(fdb + 2, 2000, "timeout_deferred_frame");
    repeat (2) @(negedge clock);
    check("deferred_fd_count", 32'(fd_count), 32'(fdb + 2));
    check("deferred_idle", 32'(busy), 32'd0);

    // Reset while the enable strobe is high.
    @(negedge clock);
    lcd_text = t_x;
    since    = 0;
    push_frame(t_x, 2);
    n = 0;
    while (!lcd_en && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("timeout_en_high", 32'(lcd_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_en", 32'(lcd_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    check("rst_mid_data", 32'(lcd_data), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    fdb  = fd_count;
    base = rises;
    push_init();
    push_frame(t_x, IDLE_GAP);
    reset = 1'b0;
    n = 0;
    while (rises < base + 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("rst_first_write", 32'(last_wr), 32'h038);
    wait_frames(fdb + 1, 1500, "timeout_after_reset");
    repeat (2) @(negedge clock);
    check("rst_fd_count", 32'(fd_count), 32'(fdb + 1));
    check("rst_final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
